gonso_sequencer: RTL and testbench

GONSO_SEQUENCER -- requirements
Module: gonso_sequencer

---
 rtl/gonso_sequencer.sv | 121 ++++++++++++
 tb/tb_gonso_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gonso_sequencer.sv
// Memory-to-serial sequencer: reads a word window w_count times and emits each
// word MSB first through a valid/ready bit handshake.
module gonso_sequencer #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              controller_en,
   input  logic              start,
   input  logic [3:0]        w_count,
   input  logic [ADDR_W-1:0] w_first,
   input  logic [ADDR_W-1:0] w_last,
   input  logic              polarity,
   output logic              progress,
   output logic              cs_n,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rdata,
   output logic              valid,
   output logic              bit_value,
   input  logic              ready
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      SHIFT = 2'd3
   } state_t;

   state_t              state;
   logic [3:0]          cfg_count;
   logic [ADDR_W-1:0]   cfg_first;
   logic [ADDR_W-1:0]   cfg_last;
   logic                cfg_pol;
   logic [3:0]          pass;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shift_reg;
   logic [4:0]          pass_next;

   assign pass_next = {1'b0, pass} + 5'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         progress  <= 1'b0;
         cs_n      <= 1'b1;
         addr      <= '0;
         valid     <= 1'b0;
         bit_value <= 1'b0;
         cfg_count <= '0;
         cfg_first <= '0;
         cfg_last  <= '0;
         cfg_pol   <= 1'b0;
         pass      <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (!controller_en) begin
         state    <= IDLE;
         progress <= 1'b0;
         valid    <= 1'b0;
         cs_n     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start && (w_count != 4'd0)) begin
                  cfg_count <= w_count;
                  cfg_first <= w_first;
                  cfg_last  <= w_last;
                  cfg_pol   <= polarity;
                  addr      <= w_first;
                  pass      <= '0;
                  progress  <= 1'b1;
                  cs_n      <= 1'b0;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               cs_n  <= 1'b1;
               state <= LOAD;
            end
            LOAD: begin
               shift_reg <= rdata;
               bit_cnt   <= '0;
               valid     <= 1'b1;
               bit_value <= rdata[DATA_W-1] ^ cfg_pol;
               state     <= SHIFT;
            end
            SHIFT: begin
               if (ready) begin
                  shift_reg <= shift_reg << 1;
                  bit_value <= shift_reg[DATA_W-2] ^ cfg_pol;
                  bit_cnt   <= bit_cnt + CNT_W'(1);
                  // Word done: advance within the window, rewind for another pass, or finish.
                  if (bit_cnt == LAST_BIT) begin
                     valid <= 1'b0;
                     if (addr != cfg_last) begin
                        addr  <= addr + ADDR_W'(1);
                        cs_n  <= 1'b0;
                        state <= FETCH;
                     end else if (pass_next < {1'b0, cfg_count}) begin
                        addr  <= cfg_first;
                        pass  <= pass_next[3:0];
                        cs_n  <= 1'b0;
                        state <= FETCH;
                     end else begin
                        progress <= 1'b0;
                        state    <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gonso_sequencer.sv
// Directed bench for gonso_sequencer with a synchronous-read memory model.
module tb_gonso_sequencer;

   logic       clk;
   logic       reset;
   logic       controller_en;
   logic       start;
   logic [3:0] w_count;
   logic [5:0] w_first;
   logic [5:0] w_last;
   logic       polarity;
   logic       progress;
   logic       cs_n;
   logic [5:0] addr;
   logic [7:0] rdata;
   logic       valid;
   logic       bit_value;
   logic       ready;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [64];
   logic [5:0] fetch_q [$];
   int         cs_low_cnt = 0;
   logic       bq [$];
   int         stab_err;

   gonso_sequencer #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .controller_en(controller_en), .start(start),
      .w_count(w_count), .w_first(w_first), .w_last(w_last), .polarity(polarity),
      .progress(progress), .cs_n(cs_n), .addr(addr), .rdata(rdata),
      .valid(valid), .bit_value(bit_value), .ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns data the cycle after cs_n is low; also logs every fetch.
   always @(posedge clk) begin
      if (!cs_n) begin
         rdata <= mem[addr];
         fetch_q.push_back(addr);
         cs_low_cnt <= cs_low_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start for one cycle, then scrambles the config inputs; returns in cycle N+1.
   task automatic start_seq(input logic [5:0] f, input logic [5:0] l, input logic [3:0] c,
                            input logic p);
      w_first = f; w_last = l; w_count = c; polarity = p;
      start = 1'b1;
      tick();
      start = 1'b0;
      w_first = f + 6'd7; w_last = l + 6'd3; w_count = 4'hF; polarity = ~p;
   endtask

   task automatic collect(input int budget, input int rper, output int tout);
      logic prev_hold;
      logic prev_bit;
      bq.delete();
      stab_err = 0;
      prev_hold = 1'b0;
      prev_bit = 1'b0;
      tout = 1;
      for (int c = 0; c < budget; c++) begin
         if (!progress) begin
            tout = 0;
            break;
         end
         ready = (rper <= 1) ? 1'b1 : ((c % rper) == 0);
         if (prev_hold && valid && (bit_value !== prev_bit)) stab_err++;
         if (valid && ready) bq.push_back(bit_value);
         prev_hold = valid && !ready;
         prev_bit = bit_value;
         tick();
      end
      ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; controller_en = 1'b1; start = 1'b0; ready = 1'b1;
      w_count = 4'd0; w_first = '0; w_last = '0; polarity = 1'b0;
      tick(); tick();
      vectors++;
      if ({progress, cs_n, addr, valid, bit_value} !== {1'b0, 1'b1, 6'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got %b required %b",
                  {progress, cs_n, addr, valid, bit_value}, {1'b0, 1'b1, 6'd0, 1'b0, 1'b0});
      end
      reset = 1'b0;
      tick();
      vectors++;
      if ({progress, cs_n, valid} !== 3'b010) begin
         miscompares++;
         $display("FAIL idle_after_reset: got %b required 010", {progress, cs_n, valid});
      end
   endtask

   task automatic test_single_word();
      logic [7:0] exp;
      exp = 8'hA5;
      start_seq(6'd5, 6'd5, 4'd1, 1'b0);
      vectors++;
      if (cs_n !== 1'b0 || addr !== 6'd5) begin
         miscompares++;
         $display("FAIL single_fetch: cs_n=%b addr=%0d required cs_n=0 addr=5", cs_n, addr);
      end
      vectors++;
      if (progress !== 1'b1) begin
         miscompares++;
         $display("FAIL single_progress: got %b required 1", progress);
      end
      tick();
      vectors++;
      if (valid !== 1'b0 || cs_n !== 1'b1) begin
         miscompares++;
         $display("FAIL single_load: valid=%b cs_n=%b required 0 1", valid, cs_n);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (valid !== 1'b1 || bit_value !== exp[7-i]) begin
            miscompares++;
            $display("FAIL single_bit%0d: valid=%b bit=%b required 1 %b", i, valid, bit_value, exp[7-i]);
         end
      end
      tick();
      vectors++;
      if (progress !== 1'b0 || valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_end: progress=%b valid=%b required 0 0", progress, valid);
      end
   endtask

   task automatic test_polarity();
      int tout;
      logic [7:0] got;
      start_seq(6'd5, 6'd5, 4'd1, 1'b1);
      collect(50, 1, tout);
      vectors++;
      if (tout != 0 || bq.size() != 8) begin
         miscompares++;
         $display("FAIL pol_count: timeout=%0d bits=%0d required 0 8", tout, bq.size());
      end else begin
         for (int i = 0; i < 8; i++) got[7-i] = bq[i];
         vectors++;
         if (got !== 8'h5A) begin
            miscompares++;
            $display("FAIL pol_bits: got %h required 5a", got);
         end
      end
   endtask

   task automatic test_wrap_window();
      int tout;
      int bad;
      logic [5:0] exp_addr [8];
      logic       exp_bits [$];
      exp_addr = '{6'd62, 6'd63, 6'd0, 6'd1, 6'd62, 6'd63, 6'd0, 6'd1};
      for (int i = 0; i < 8; i++)
         for (int b = 7; b >= 0; b--) exp_bits.push_back(mem[exp_addr[i]][b]);
      fetch_q.delete();
      start_seq(6'd62, 6'd1, 4'd2, 1'b0);
      collect(400, 1, tout);
      vectors++;
      if (tout != 0 || bq.size() != 64) begin
         miscompares++;
         $display("FAIL wrap_count: timeout=%0d bits=%0d required 0 64", tout, bq.size());
      end
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (i >= fetch_q.size() || fetch_q[i] !== exp_addr[i]) bad++;
      vectors++;
      if (bad != 0 || fetch_q.size() != 8) begin
         miscompares++;
         $display("FAIL wrap_addr_order: %0d wrong of %0d fetches required 0 of 8", bad, fetch_q.size());
      end
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (i >= bq.size() || bq[i] !== exp_bits[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL wrap_bits: %0d wrong bits required 0", bad);
      end
   endtask

   task automatic test_ready_throttle();
      int tout;
      int bad;
      logic [7:0] exp;
      exp = 8'hC6;
      start_seq(6'd3, 6'd3, 4'd2, 1'b0);
      collect(300, 3, tout);
      vectors++;
      if (tout != 0 || bq.size() != 16) begin
         miscompares++;
         $display("FAIL throttle_count: timeout=%0d bits=%0d required 0 16", tout, bq.size());
      end
      bad = 0;
      for (int i = 0; i < 16; i++)
         if (i >= bq.size() || bq[i] !== exp[7 - (i % 8)]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL throttle_bits: %0d wrong bits required 0", bad);
      end
      vectors++;
      if (stab_err != 0) begin
         miscompares++;
         $display("FAIL throttle_hold: %0d unstable cycles required 0", stab_err);
      end
   endtask

   task automatic test_enable_abort();
      int tout;
      logic [7:0] got;
      start_seq(6'd10, 6'd11, 4'd3, 1'b0);
      for (int c = 0; c < 10; c++) begin
         if (valid) break;
         tick();
      end
      vectors++;
      if (valid !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_reach_shift: valid=%b required 1", valid);
      end
      tick(); tick(); tick();
      controller_en = 1'b0;
      tick();
      vectors++;
      if ({valid, progress, cs_n} !== 3'b001) begin
         miscompares++;
         $display("FAIL abort_outputs: got %b required 001", {valid, progress, cs_n});
      end
      controller_en = 1'b1;
      tick(); tick();
      vectors++;
      if (progress !== 1'b0 || valid !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_no_resume: progress=%b valid=%b required 0 0", progress, valid);
      end
      start_seq(6'd10, 6'd11, 4'd3, 1'b0);
      vectors++;
      if (addr !== 6'd10 || cs_n !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_restart: addr=%0d cs_n=%b required 10 0", addr, cs_n);
      end
      collect(400, 1, tout);
      vectors++;
      if (tout != 0 || bq.size() != 48) begin
         miscompares++;
         $display("FAIL abort_rerun_count: timeout=%0d bits=%0d required 0 48", tout, bq.size());
      end else begin
         for (int i = 0; i < 8; i++) got[7-i] = bq[i];
         vectors++;
         if (got !== 8'hF0) begin
            miscompares++;
            $display("FAIL abort_rerun_first: got %h required f0", got);
         end
      end
   endtask

   task automatic test_reset_mid();
      start_seq(6'd20, 6'd25, 4'd4, 1'b1);
      for (int i = 0; i < 6; i++) tick();
      reset = 1'b1; start = 1'b1; w_count = 4'd2;
      tick();
      reset = 1'b0; start = 1'b0;
      vectors++;
      if ({progress, cs_n, addr, valid, bit_value} !== {1'b0, 1'b1, 6'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid: got %b required %b",
                  {progress, cs_n, addr, valid, bit_value}, {1'b0, 1'b1, 6'd0, 1'b0, 1'b0});
      end
      tick(); tick();
      vectors++;
      if (progress !== 1'b0 || cs_n !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_priority: progress=%b cs_n=%b required 0 1", progress, cs_n);
      end
   endtask

   task automatic test_zero_count();
      int base;
      base = cs_low_cnt;
      start_seq(6'd7, 6'd7, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (progress !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_idle%0d: progress=%b valid=%b required 0 0", i, progress, valid);
         end
         tick();
      end
      vectors++;
      if (cs_low_cnt != base) begin
         miscompares++;
         $display("FAIL zero_no_fetch: cs_n low cycles=%0d required 0", cs_low_cnt - base);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'(i * 29 + 7);
      mem[3]  = 8'hC6;
      mem[5]  = 8'hA5;
      mem[10] = 8'hF0;
      mem[11] = 8'h0F;
      test_reset();
      test_single_word();
      test_polarity();
      test_wrap_window();
      test_ready_throttle();
      test_enable_abort();
      test_reset_mid();
      test_zero_count();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
